// File: rtl/ilu_pkg.sv
// Shared types and helpers for the I-cache lookup/miss stage.
package ilu_pkg;

  localparam int LINE_OFS = 4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MEMR = 3'd1,
    S_ICWT = 3'd2,
    S_ICW2 = 3'd3,
    S_ICW3 = 3'd4,
    S_LDRD = 3'd5
  } ic_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ilu_stage_nway_tag_1r1w.sv
// One way of tag storage: synchronous write, registered read (data one cycle after address).
module ic_tag_1r1w #(
  parameter int IRWIDTH = 10,
  parameter int TW      = 18
) (
  input  logic               clk,
  input  logic [IRWIDTH-1:0] raddr,
  output logic [TW-1:0]      rdata,
  input  logic               we,
  input  logic [IRWIDTH-1:0] waddr,
  input  logic [TW-1:0]      wdata
);

  logic [TW-1:0] mem [2**IRWIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/ilu_stage_nway.sv
// N-way I-cache tag lookup and miss/fill controller; hit one cycle after pc_if, stalls the pipe on miss.
// Data-RAM write index is the line-aligned word index {set, 2'b00}; victim is first invalid way, else round-robin.
module ilu_stage_nway
  import ilu_pkg::*;
#(
  parameter int IWIDTH = 14,
  parameter int WAYS   = 2,
  localparam int WAYW  = (WAYS > 1) ? clog2(WAYS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [29:0]       pc_if,
  input  logic              pc_valid_id,
  input  logic              rst_pipe,
  input  logic              start_icflush,
  input  logic              ic_rdat_m_valid,
  output logic              ic_tag_hit_id,
  output logic [WAYW-1:0]   ic_hit_way_id,
  output logic              ic_stall,
  output logic              ic_stall_fin,
  output logic              ic_stall_fin2,
  output logic              icr_start_rq,
  output logic [31:0]       ic_rin_addr,
  output logic [IWIDTH-3:0] ic_ram_wadr_all,
  output logic [WAYW-1:0]   ic_ram_wway,
  output logic              ic_flush_pending
);

  localparam int IRW  = IWIDTH - LINE_OFS;
  localparam int SETS = 2**IRW;
  localparam int TW   = 32 - IWIDTH;

  ic_state_e state, state_nxt;

  // PCs are kept as line addresses (byte address [31:4])
  logic [27:0]     pc_id, keeper;
  logic [IRW-1:0]  idx_q, look_idx, keep_idx;
  logic [TW-1:0]   id_tag, keep_tag;
  logic [TW-1:0]   tag_rd [WAYS];
  logic [WAYS-1:0] hits;
  logic [WAYS-1:0] valid [SETS];
  logic [WAYW-1:0] ptr [SETS];
  logic [WAYW-1:0] way_q, vict_way, hit_way;
  logic            vict_ptr, from_ptr_q, req_q, flush_pend;
  logic            hit, miss, fill, do_flush;
  logic            unused_pc_lo;

  assign unused_pc_lo = ^pc_if[1:0];

  assign look_idx = (state == S_IDLE || state == S_LDRD) ? pc_if[IRW+1:2] : keeper[IRW-1:0];
  assign id_tag   = pc_id[27:IRW];
  assign keep_idx = keeper[IRW-1:0];
  assign keep_tag = keeper[27:IRW];
  assign fill     = (state == S_MEMR) && ic_rdat_m_valid;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    ic_tag_1r1w #(.IRWIDTH(IRW), .TW(TW)) u_tag (
      .clk   (clk),
      .raddr (look_idx),
      .rdata (tag_rd[w]),
      .we    (fill && (way_q == WAYW'(w))),
      .waddr (keep_idx),
      .wdata (keep_tag)
    );
    assign hits[w] = valid[idx_q][w] && (tag_rd[w] == id_tag) && pc_valid_id;
  end

  always_comb begin
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hits[w]) hit_way = WAYW'(w);
    end
  end

  always_comb begin
    vict_way = ptr[idx_q];
    vict_ptr = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[idx_q][w]) begin
        vict_way = WAYW'(w);
        vict_ptr = 1'b0;
      end
    end
  end

  assign hit  = |hits;
  assign miss = pc_valid_id && !hit;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (miss) state_nxt = S_MEMR;
      S_MEMR:  if (ic_rdat_m_valid) state_nxt = S_ICWT;
      S_ICWT:  state_nxt = S_ICW2;
      S_ICW2:  state_nxt = S_ICW3;
      S_ICW3:  state_nxt = S_LDRD;
      S_LDRD:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (rst_pipe) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  assign ic_stall      = (state != S_IDLE && state != S_LDRD) || (miss && state != S_LDRD);
  assign ic_stall_fin  = (state == S_ICW3);
  assign ic_stall_fin2 = (state == S_LDRD);

  // A flush that cannot apply now waits for the refill to retire
  assign do_flush = ((state == S_IDLE) && !miss && start_icflush) ||
                    ((state == S_LDRD) && (flush_pend || start_icflush));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        ptr[s]   <= '0;
      end
    end else if (rst_pipe || do_flush) begin
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        ptr[s]   <= '0;
      end
    end else if (fill) begin
      valid[keep_idx][way_q] <= 1'b1;
      if (from_ptr_q) ptr[keep_idx] <= (WAYS > 1) ? ptr[keep_idx] + WAYW'(1) : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_pend <= 1'b0;
    end else if (rst_pipe || do_flush) begin
      flush_pend <= 1'b0;
    end else if (start_icflush) begin
      flush_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_id <= '0;
      idx_q <= '0;
    end else begin
      idx_q <= look_idx;
      if (!ic_stall && !ic_stall_fin) pc_id <= pc_if[29:2];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keeper     <= '0;
      way_q      <= '0;
      from_ptr_q <= 1'b0;
      req_q      <= 1'b0;
    end else if (rst_pipe) begin
      keeper     <= '0;
      way_q      <= '0;
      from_ptr_q <= 1'b0;
      req_q      <= 1'b0;
    end else begin
      req_q <= (state == S_IDLE) && miss;
      if ((state == S_IDLE) && miss) begin
        keeper     <= pc_id;
        way_q      <= vict_way;
        from_ptr_q <= vict_ptr;
      end
    end
  end

  assign ic_tag_hit_id    = hit;
  assign ic_hit_way_id    = hit_way;
  assign icr_start_rq     = req_q;
  assign ic_rin_addr      = {keeper, 4'b0000};
  assign ic_ram_wadr_all  = {keep_idx, 2'b00};
  assign ic_ram_wway      = way_q;
  assign ic_flush_pending = flush_pend;

endmodule

// File: tb/tb_ilu_stage_nway.sv
// Bench for ilu_stage_nway: a 2-way/IWIDTH=14 instance and a 1-way/IWIDTH=12 instance, checked against a set/way cache model.
module tb_ilu_stage_nway;

  logic        clk = 1'b0;
  logic        rst, rst_pipe, start_icflush, rdat, vld, sel;
  logic [29:0] pc_if;
  int          errors = 0;
  int          checks = 0;

  logic        hit0, stall0, fin0, fin20, rq0, fp0;
  logic [0:0]  way0, wway0;
  logic [31:0] rin0;
  logic [11:0] wadr0;
  logic        hit1, stall1, fin1, fin21, rq1, fp1;
  logic [0:0]  way1, wway1;
  logic [31:0] rin1;
  logic [9:0]  wadr1;

  always #5 clk = ~clk;

  ilu_stage_nway #(.IWIDTH(14), .WAYS(2)) u0 (
    .clk(clk), .rst(rst), .pc_if(pc_if), .pc_valid_id(vld & ~sel),
    .rst_pipe(rst_pipe & ~sel), .start_icflush(start_icflush & ~sel),
    .ic_rdat_m_valid(rdat & ~sel), .ic_tag_hit_id(hit0), .ic_hit_way_id(way0),
    .ic_stall(stall0), .ic_stall_fin(fin0), .ic_stall_fin2(fin20),
    .icr_start_rq(rq0), .ic_rin_addr(rin0), .ic_ram_wadr_all(wadr0),
    .ic_ram_wway(wway0), .ic_flush_pending(fp0));

  ilu_stage_nway #(.IWIDTH(12), .WAYS(1)) u1 (
    .clk(clk), .rst(rst), .pc_if(pc_if), .pc_valid_id(vld & sel),
    .rst_pipe(rst_pipe & sel), .start_icflush(start_icflush & sel),
    .ic_rdat_m_valid(rdat & sel), .ic_tag_hit_id(hit1), .ic_hit_way_id(way1),
    .ic_stall(stall1), .ic_stall_fin(fin1), .ic_stall_fin2(fin21),
    .icr_start_rq(rq1), .ic_rin_addr(rin1), .ic_ram_wadr_all(wadr1),
    .ic_ram_wway(wway1), .ic_flush_pending(fp1));

  logic        hit_s, stall_s, fin_s, fin2_s, rq_s, fp_s;
  logic [0:0]  way_s, wway_s;
  logic [31:0] rin_s;
  logic [11:0] wadr_s;
  assign hit_s   = sel ? hit1 : hit0;
  assign stall_s = sel ? stall1 : stall0;
  assign fin_s   = sel ? fin1 : fin0;
  assign fin2_s  = sel ? fin21 : fin20;
  assign rq_s    = sel ? rq1 : rq0;
  assign fp_s    = sel ? fp1 : fp0;
  assign way_s   = sel ? way1 : way0;
  assign wway_s  = sel ? wway1 : wway0;
  assign rin_s   = sel ? rin1 : rin0;
  assign wadr_s  = sel ? {2'b00, wadr1} : wadr0;

  // Cache model: per instance, per set, per way tag/valid plus a round-robin pointer
  bit          m_val [2][1024][2];
  int unsigned m_tag [2][1024][2];
  int          m_ptr [2][1024];

  task automatic model_clear(input int d);
    for (int s = 0; s < 1024; s++) begin
      m_ptr[d][s] = 0;
      for (int w = 0; w < 2; w++) m_val[d][s][w] = 1'b0;
    end
  endtask

  // One fetch: pc_if for a cycle, then ID-valid; on miss run the refill with 'lat' idle MEMR cycles.
  // fmode: 0 none, 1 flush pulse at M+1, 2 flush together with line data.
  task automatic access(input logic [31:0] addr, input int lat, input int fmode);
    int iw, nw, idx, hw, vw;
    int unsigned tg;
    bit h;
    iw  = sel ? 12 : 14;
    nw  = sel ? 1 : 2;
    idx = int'((addr >> 4) & ((32'd1 << (iw - 4)) - 1));
    tg  = addr >> iw;
    h = 1'b0; hw = 0;
    for (int w = nw - 1; w >= 0; w--)
      if (m_val[sel][idx][w] && m_tag[sel][idx][w] == tg) begin h = 1'b1; hw = w; end
    @(negedge clk); pc_if = addr[31:2]; vld = 1'b0;
    @(negedge clk); vld = 1'b1; #1;
    checks++; if (hit_s !== h) begin errors++; $display("FAIL hit addr=%h got=%0b want=%0b", addr, hit_s, h); end
    checks++; if (way_s !== 1'(hw)) begin errors++; $display("FAIL hit_way addr=%h got=%0d want=%0d", addr, way_s, hw); end
    checks++; if (stall_s !== !h) begin errors++; $display("FAIL stall_at_M addr=%h got=%0b want=%0b", addr, stall_s, !h); end
    if (h) begin
      @(negedge clk); vld = 1'b0;
      return;
    end
    vw = -1;
    for (int w = nw - 1; w >= 0; w--) if (!m_val[sel][idx][w]) vw = w;
    if (vw < 0) begin
      vw = m_ptr[sel][idx];
      m_ptr[sel][idx] = (m_ptr[sel][idx] + 1) % nw;
    end
    @(negedge clk);
    checks++; if (rq_s !== 1'b1) begin errors++; $display("FAIL start_rq_M1 addr=%h got=%0b want=1", addr, rq_s); end
    checks++; if (rin_s !== (addr & 32'hFFFF_FFF0)) begin errors++; $display("FAIL rin_addr got=%h want=%h", rin_s, addr & 32'hFFFF_FFF0); end
    checks++; if (wway_s !== 1'(vw)) begin errors++; $display("FAIL victim addr=%h got=%0d want=%0d", addr, wway_s, vw); end
    checks++; if (wadr_s !== 12'(idx << 2)) begin errors++; $display("FAIL wadr got=%h want=%h", wadr_s, 12'(idx << 2)); end
    if (fmode == 1) start_icflush = 1'b1;
    for (int i = 0; i < lat; i++) begin
      @(negedge clk); start_icflush = 1'b0; #1;
      checks++; if (rq_s !== 1'b0 || stall_s !== 1'b1) begin errors++; $display("FAIL memr_wait rq=%0b stall=%0b want rq=0 stall=1", rq_s, stall_s); end
    end
    @(negedge clk); start_icflush = (fmode == 2); rdat = 1'b1; #1;
    checks++; if (stall_s !== 1'b1 || fin_s !== 1'b0) begin errors++; $display("FAIL at_V stall=%0b fin=%0b want 1/0", stall_s, fin_s); end
    m_val[sel][idx][vw] = 1'b1;
    m_tag[sel][idx][vw] = tg;
    @(negedge clk); rdat = 1'b0; start_icflush = 1'b0; #1;
    checks++; if (stall_s !== 1'b1 || fin_s !== 1'b0 || fin2_s !== 1'b0) begin errors++; $display("FAIL icwt stall=%0b fin=%0b fin2=%0b want 1/0/0", stall_s, fin_s, fin2_s); end
    checks++; if (fp_s !== (fmode != 0)) begin errors++; $display("FAIL flush_pending_V1 got=%0b want=%0b", fp_s, fmode != 0); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (fin_s !== 1'b1 || fin2_s !== 1'b0 || stall_s !== 1'b1) begin errors++; $display("FAIL icw3 fin=%0b fin2=%0b stall=%0b want 1/0/1", fin_s, fin2_s, stall_s); end
    @(negedge clk);
    checks++; if (fin2_s !== 1'b1 || fin_s !== 1'b0 || stall_s !== 1'b0) begin errors++; $display("FAIL ldrd fin2=%0b fin=%0b stall=%0b want 1/0/0", fin2_s, fin_s, stall_s); end
    checks++; if (hit_s !== 1'b1 || way_s !== 1'(vw)) begin errors++; $display("FAIL refetch_hit hit=%0b way=%0d want 1/%0d", hit_s, way_s, vw); end
    checks++; if (wway_s !== 1'(vw) || fp_s !== (fmode != 0)) begin errors++; $display("FAIL ldrd_hold wway=%0d fp=%0b want %0d/%0b", wway_s, fp_s, vw, fmode != 0); end
    vld = 1'b0;
    @(negedge clk);
    checks++; if (fp_s !== 1'b0 || fin2_s !== 1'b0) begin errors++; $display("FAIL idle_after fp=%0b fin2=%0b want 0/0", fp_s, fin2_s); end
    if (fmode != 0) model_clear(sel);
  endtask

  task automatic test_reset();
    rst = 1'b1; rst_pipe = 1'b0; start_icflush = 1'b0; rdat = 1'b0; vld = 1'b0; sel = 1'b0; pc_if = '0;
    repeat (2) @(negedge clk);
    checks++; if ({hit0, way0, stall0, fin0, fin20, rq0, fp0, wway0} !== 8'h0) begin errors++; $display("FAIL reset_ctl0 got=%b want=0", {hit0, way0, stall0, fin0, fin20, rq0, fp0, wway0}); end
    checks++; if (rin0 !== 32'h0 || wadr0 !== 12'h0) begin errors++; $display("FAIL reset_addr0 rin=%h wadr=%h want 0", rin0, wadr0); end
    checks++; if ({hit1, stall1, fin1, fin21, rq1, fp1, wway1} !== 7'h0 || rin1 !== 32'h0) begin errors++; $display("FAIL reset_u1 got=%b rin=%h want 0", {hit1, stall1, fin1, fin21, rq1, fp1, wway1}, rin1); end
    rst = 1'b0;
    model_clear(0); model_clear(1);
    @(negedge clk);
  endtask

  task automatic test_cold_and_conflict();
    sel = 1'b0;
    access(32'h0000_0100, 2, 0);
    access(32'h0000_0100, 0, 0);
    access(32'h0000_4100, 1, 0);
    access(32'h0000_8100, 0, 0);
    access(32'h0000_C100, 3, 0);
    access(32'h0000_4100, 0, 0);
    access(32'h0000_C100, 0, 0);
  endtask

  task automatic test_flush_idle();
    sel = 1'b0;
    access(32'h0000_0100, 1, 0);
    access(32'h0000_0100, 0, 0);
    @(negedge clk); start_icflush = 1'b1;
    @(negedge clk); start_icflush = 1'b0; #1;
    checks++; if (fp_s !== 1'b0) begin errors++; $display("FAIL flush_idle_pending got=%0b want=0", fp_s); end
    model_clear(0);
    access(32'h0000_0100, 0, 0);
  endtask

  task automatic test_flush_memr();
    sel = 1'b0;
    access(32'h0000_0200, 2, 1);
    access(32'h0000_0200, 0, 0);
    access(32'h0000_0300, 0, 2);
    access(32'h0000_0300, 1, 0);
  endtask

  task automatic test_rst_pipe();
    sel = 1'b0;
    @(negedge clk); pc_if = 30'h0000_0500 >> 2; vld = 1'b0;
    @(negedge clk); vld = 1'b1;
    @(negedge clk);
    @(negedge clk); rdat = 1'b1;
    @(negedge clk); rdat = 1'b0;
    @(negedge clk); rst_pipe = 1'b1; vld = 1'b0;
    @(negedge clk); rst_pipe = 1'b0; #1;
    checks++; if (stall_s !== 1'b0 || fin_s !== 1'b0 || fin2_s !== 1'b0) begin errors++; $display("FAIL rst_pipe_state stall=%0b fin=%0b fin2=%0b want 0", stall_s, fin_s, fin2_s); end
    checks++; if (rin_s !== 32'h0 || wway_s !== 1'b0 || rq_s !== 1'b0) begin errors++; $display("FAIL rst_pipe_keeper rin=%h wway=%0d rq=%0b want 0", rin_s, wway_s, rq_s); end
    rdat = 1'b1;
    @(negedge clk); rdat = 1'b0; #1;
    checks++; if (stall_s !== 1'b0 || rq_s !== 1'b0 || fin_s !== 1'b0) begin errors++; $display("FAIL stray_rdat stall=%0b rq=%0b fin=%0b want 0", stall_s, rq_s, fin_s); end
    @(negedge clk);
    checks++; if (fin_s !== 1'b0 || fin2_s !== 1'b0) begin errors++; $display("FAIL stray_rdat_late fin=%0b fin2=%0b want 0", fin_s, fin2_s); end
    model_clear(0);
    access(32'h0000_0500, 0, 0);
    access(32'h0000_0300, 0, 0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    sel = 1'b0;
    for (int n = 0; n < 60; n++) begin
      a = (32'($urandom_range(0, 3)) << 14) | (32'($urandom_range(0, 3)) << 4) | (32'($urandom_range(0, 3)) << 2);
      access(a, int'($urandom_range(0, 3)), 0);
      if ($urandom_range(0, 11) == 0) begin
        @(negedge clk); start_icflush = 1'b1;
        @(negedge clk); start_icflush = 1'b0; #1;
        checks++; if (fp_s !== 1'b0) begin errors++; $display("FAIL rand_flush_pending got=%0b want=0", fp_s); end
        model_clear(0);
      end
    end
  endtask

  task automatic test_ways1();
    sel = 1'b1;
    for (int n = 0; n < 6; n++) access((n % 2) ? 32'h0000_1100 : 32'h0000_0100, n % 3, 0);
    access(32'h0000_0100, 0, 0);
    access(32'h0000_0100, 0, 0);
    sel = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cold_and_conflict();
    test_flush_idle();
    test_flush_memr();
    test_rst_pipe();
    test_random();
    test_ways1();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
